// File: rtl/t05_keyentry_ctrl.sv
// Keypad entry controller: debounces encoded key presses and builds a 4-digit
// BCD entry with digit, backspace, clear and enter keys.
`timescale 1ns/1ps
module t05_keyentry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  key_code,
    input  logic        key_strobe,
    input  logic        entry_ready,
    output logic [15:0] entry_value,
    output logic        entry_valid,
    output logic [15:0] display_digits,
    output logic [2:0]  digit_count,
    output logic        key_error,
    output logic [1:0]  debug_state
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] WAIT_RELEASE = 2'd2;
    localparam logic [1:0] OUTPUT       = 2'd3;

    localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_CYCLES - 1);

    localparam logic [4:0] KEY_DIGIT_MAX = 5'd9;
    localparam logic [4:0] KEY_BACKSPACE = 5'd10;
    localparam logic [4:0] KEY_CLEAR     = 5'd11;
    localparam logic [4:0] KEY_ENTER     = 5'd12;

    logic [1:0]  state_q,   state_d;
    logic [3:0]  cnt_q,     cnt_d;
    logic [4:0]  code_q,    code_d;
    logic [15:0] disp_q,    disp_d;
    logic [2:0]  count_q,   count_d;
    logic [15:0] value_q,   value_d;
    logic        valid_q,   valid_d;
    logic        err_q,     err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        disp_d  = disp_q;
        count_d = count_q;
        value_d = value_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (key_strobe) begin
                    code_d  = key_code;
                    cnt_d   = 4'd1;
                    state_d = DEBOUNCE;
                end
            end

            DEBOUNCE: begin
                if (!key_strobe) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (key_code != code_q) begin
                    // A code change restarts the stability window on the new key.
                    code_d = key_code;
                    cnt_d  = 4'd1;
                end else if (cnt_q < LAST_CNT) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d   = 4'd0;
                    state_d = WAIT_RELEASE;
                    if (code_q <= KEY_DIGIT_MAX) begin
                        if (count_q < 3'd4) begin
                            disp_d  = {disp_q[11:0], code_q[3:0]};
                            count_d = count_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (code_q == KEY_BACKSPACE) begin
                        if (count_q != 3'd0) begin
                            disp_d  = disp_q >> 4;
                            count_d = count_q - 3'd1;
                        end
                    end else if (code_q == KEY_CLEAR) begin
                        disp_d  = 16'h0000;
                        count_d = 3'd0;
                    end else if (code_q == KEY_ENTER) begin
                        if (count_q != 3'd0) begin
                            value_d = disp_q;
                            valid_d = 1'b1;
                            state_d = OUTPUT;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            WAIT_RELEASE: begin
                // Counts consecutive released cycles; any press restarts the count.
                if (key_strobe) begin
                    cnt_d = 4'd0;
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            OUTPUT: begin
                if (entry_ready) begin
                    valid_d = 1'b0;
                    disp_d  = 16'h0000;
                    count_d = 3'd0;
                    cnt_d   = 4'd0;
                    state_d = WAIT_RELEASE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            code_q  <= 5'd0;
            disp_q  <= 16'h0000;
            count_q <= 3'd0;
            value_q <= 16'h0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            disp_q  <= disp_d;
            count_q <= count_d;
            value_q <= value_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign entry_value    = value_q;
    assign entry_valid    = valid_q;
    assign display_digits = disp_q;
    assign digit_count    = count_q;
    assign key_error      = err_q;
    assign debug_state    = state_q;

endmodule
